pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-stage program-counter generator for the 5-stage MIPS pipeline.
//  - Holds the fetch PC and selects the next PC among: sequential +4, branch/jump redirect,
//    exception vector and ERET return.
//  - A redirect that resolves while fetch is stalled is buffered and applied when the stall releases.
//  - Flags fetch-address errors (AdEL) to CP0 and pulses a flush on every non-sequential PC.
// PARAMETERS
//  XLEN        32             PC width in bits (>= 8)
//  RESET_VEC   32'h0000_3000  PC value after reset
//  EXC_VEC     32'h0000_4180  exception handler entry address
//  IMEM_BASE   32'h0000_3000  lowest legal fetch address
//  IMEM_WORDS  4096           instruction memory size in words; legal range [BASE, BASE+4*WORDS)
// PORTS
//  clk           in   1     clock, rising edge
//  reset         in   1     synchronous, active-high
//  stall_i       in   1     hazard unit: hold fetch PC this cycle
//  br_taken_i    in   1     D-stage branch/jump resolved taken
//  br_target_i   in   XLEN  target address for br_taken_i
//  exc_req_i     in   1     CP0: enter exception handler
//  eret_i        in   1     CP0: return from exception
//  epc_i         in   XLEN  return address for eret_i
//  pc_o          out  XLEN  current fetch PC (registered)
//  pc_plus4_o    out  XLEN  pc_o + 4 (combinational)
//  redirect_o    out  1     1-cycle pulse: pc_o was loaded from a non-sequential source
//  pend_o        out  1     a buffered redirect is waiting (debug/observability)
//  fetch_adel_o  out  1     pc_o misaligned or outside IMEM range (combinational from pc_o)
// BEHAVIOUR
//  - Reset: pc_o=RESET_VEC, redirect_o=0, pend_o=0, pending target register=0. Reset wins over all inputs.
//  - Two-state FSM on the pending flag: RUN (pend_o=0) and PEND (pend_o=1).
//  - Next-PC priority, evaluated every cycle, first match wins:
//    1. exc_req_i -> pc=EXC_VEC, redirect_o=1, state->RUN. Overrides stall.
//    2. eret_i -> pc=epc_i, redirect_o=1, state->RUN. Overrides stall.
//    3. stall_i -> pc held, redirect_o=0.
//       - If br_taken_i: latch br_target_i into pending, state->PEND. Latest target overwrites an older one.
//       - Otherwise: pending unchanged.
//    4. br_taken_i -> pc=br_target_i, redirect_o=1, state->RUN. A live redirect beats a stale pending one.
//    5. state PEND -> pc=pending target, redirect_o=1, state->RUN.
//    6. else -> pc=pc_o+4, redirect_o=0.
//  - Latency: a redirect presented at edge N with no stall appears on pc_o after edge N.
//    - Buffered redirect: appears after the first edge with stall_i=0.
//  - Arithmetic: +4 is modulo 2^XLEN; pc 2^XLEN-4 wraps to 0. No saturation.
//  - fetch_adel_o=1 iff pc_o[1:0]!=0, pc_o<IMEM_BASE or pc_o>=IMEM_BASE+4*IMEM_WORDS.
//    - Range compare is done in XLEN+1 bits so the upper bound never overflows.
//    - The PC still advances normally; CP0 is responsible for raising exc_req_i.
//  - Targets (br_target_i, epc_i) are loaded unmodified; a misaligned target is reported via fetch_adel_o.
//  - exc_req_i and eret_i both high: exc_req_i wins, eret_i ignored.
//  - Reset while in PEND: pending is discarded, pc_o=RESET_VEC.
//  - No X propagation: all registers are explicitly reset.
// TESTING
//  1. Reset, then 3 free cycles -> pc_o 0x3000, 0x3004, 0x3008, 0x300C; redirect_o=0 throughout.
//  2. pc_o=0x3010, stall_i=1 for 3 cycles -> pc_o stays 0x3010; release -> 0x3014.
//  3. pc_o=0x3010, stall_i=1, br_taken_i=1 with target 0x3100 for 1 cycle, then stall_i=1 for 2 more cycles:
//     - pend_o=1 and pc_o=0x3010 throughout the stall.
//     - After release: pc_o=0x3100, redirect_o=1 for 1 cycle, pend_o=0.
//  4. In PEND (pending target 0x3100), assert exc_req_i with stall_i=1 -> pc_o=0x4180, pend_o=0;
//     next cycle pc_o=0x4184.
//  5. eret_i with epc_i=0x3024 -> pc_o=0x3024, redirect_o=1.
//     br_taken_i with target 0x3102 -> fetch_adel_o=1; target 0x7000 -> fetch_adel_o=1.
//  6. Assert reset while pend_o=1 -> pc_o=0x3000, pend_o=0.
//     Also check wrap: RESET_VEC=32'hFFFF_FFFC -> after 1 cycle pc_o=0.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with buffered redirect under stall
// Next-PC priority: exception, ERET, stall (buffers branch), live branch, pending branch, +4.
module pc_gen #(
  parameter int unsigned          XLEN       = 32,
  parameter logic [XLEN-1:0]      RESET_VEC  = XLEN'('h0000_3000),
  parameter logic [XLEN-1:0]      EXC_VEC    = XLEN'('h0000_4180),
  parameter logic [XLEN-1:0]      IMEM_BASE  = XLEN'('h0000_3000),
  parameter int unsigned          IMEM_WORDS = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            exc_req_i,
  input  logic            eret_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            redirect_o,
  output logic            pend_o,
  output logic            fetch_adel_o
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

  // One extra bit keeps BASE + 4*WORDS from wrapping at the top of the address space.
  localparam logic [XLEN:0] LO_BOUND = {1'b0, IMEM_BASE};
  localparam logic [XLEN:0] HI_BOUND = LO_BOUND + ((XLEN+1)'(IMEM_WORDS) << 2);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic            redirect_q;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + XLEN'(4);
  assign redirect_o = redirect_q;
  assign pend_o     = (state_q == PEND);

  always_comb begin
    fetch_adel_o = (pc_q[1:0] != 2'b00)
                || ({1'b0, pc_q} < LO_BOUND)
                || ({1'b0, pc_q} >= HI_BOUND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      pend_tgt_q <= '0;
      redirect_q <= 1'b0;
    end else if (exc_req_i) begin
      state_q    <= RUN;
      pc_q       <= EXC_VEC;
      redirect_q <= 1'b1;
    end else if (eret_i) begin
      state_q    <= RUN;
      pc_q       <= epc_i;
      redirect_q <= 1'b1;
    end else if (stall_i) begin
      redirect_q <= 1'b0;
      if (br_taken_i) begin
        state_q    <= PEND;
        pend_tgt_q <= br_target_i;
      end
    end else if (br_taken_i) begin
      state_q    <= RUN;
      pc_q       <= br_target_i;
      redirect_q <= 1'b1;
    end else if (state_q == PEND) begin
      state_q    <= RUN;
      pc_q       <= pend_tgt_q;
      redirect_q <= 1'b1;
    end else begin
      pc_q       <= pc_plus4_o;
      redirect_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
// A second instance with RESET_VEC at the top of the address space covers the +4 wrap.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, exc_req, eret;
  logic [31:0] br_target, epc;
  logic [31:0] pc, pc_plus4, w_pc, w_pc_plus4;
  logic        redirect, pend, adel, w_redirect, w_pend, w_adel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .reset(reset), .stall_i(stall), .br_taken_i(br_taken),
    .br_target_i(br_target), .exc_req_i(exc_req), .eret_i(eret), .epc_i(epc),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .redirect_o(redirect), .pend_o(pend),
    .fetch_adel_o(adel)
  );

  pc_gen #(.RESET_VEC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall_i(1'b0), .br_taken_i(1'b0),
    .br_target_i(32'h0), .exc_req_i(1'b0), .eret_i(1'b0), .epc_i(32'h0),
    .pc_o(w_pc), .pc_plus4_o(w_pc_plus4), .redirect_o(w_redirect), .pend_o(w_pend),
    .fetch_adel_o(w_adel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic x, input logic e, input logic [31:0] ep);
    stall = s; br_taken = b; br_target = t; exc_req = x; eret = e; epc = ep;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_pc", pc, 32'h3000);
    check("rst_redirect", {31'b0, redirect}, 0);
    check("rst_pend", {31'b0, pend}, 0);
    check("rst_plus4", pc_plus4, 32'h3004);
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", w_pc_plus4, 32'h0);
    check("wrap_adel_top", {31'b0, w_adel}, 1);

    reset = 1'b0;
    step();
    check("wrap_pc", w_pc, 32'h0);
    check("seq_pc1", pc, 32'h3004);
    check("seq_redir1", {31'b0, redirect}, 0);
    step();
    check("seq_pc2", pc, 32'h3008);
    step();
    check("seq_pc3", pc, 32'h300C);
    check("seq_redir3", {31'b0, redirect}, 0);
    step();
    check("seq_pc4", pc, 32'h3010);

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pc, 32'h3010);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("stall_release", pc, 32'h3014);

    drive(1, 1, 32'h3100, 0, 0, 0);
    step();
    check("pend_set", {31'b0, pend}, 1);
    check("pend_pc", pc, 32'h3014);
    check("pend_redir", {31'b0, redirect}, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("pend_hold", {31'b0, pend}, 1);
      check("pend_pc_hold", pc, 32'h3014);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("pend_apply_pc", pc, 32'h3100);
    check("pend_apply_redir", {31'b0, redirect}, 1);
    check("pend_cleared", {31'b0, pend}, 0);
    step();
    check("after_pend_pc", pc, 32'h3104);
    check("after_pend_redir", {31'b0, redirect}, 0);

    drive(1, 1, 32'h3100, 0, 0, 0);
    step();
    check("pend_again", {31'b0, pend}, 1);
    drive(1, 0, 0, 1, 0, 0);
    step();
    check("exc_pc", pc, 32'h4180);
    check("exc_pend", {31'b0, pend}, 0);
    check("exc_redir", {31'b0, redirect}, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("exc_next", pc, 32'h4184);
    check("exc_next_adel", {31'b0, adel}, 0);

    drive(0, 0, 0, 1, 1, 32'h3024);
    step();
    check("exc_over_eret", pc, 32'h4180);
    drive(0, 0, 0, 0, 1, 32'h3024);
    step();
    check("eret_pc", pc, 32'h3024);
    check("eret_redir", {31'b0, redirect}, 1);

    drive(0, 1, 32'h3102, 0, 0, 0);
    step();
    check("misalign_pc", pc, 32'h3102);
    check("misalign_adel", {31'b0, adel}, 1);
    drive(0, 1, 32'h7000, 0, 0, 0);
    step();
    check("hi_adel", {31'b0, adel}, 1);
    drive(0, 1, 32'h6FFC, 0, 0, 0);
    step();
    check("last_word_adel", {31'b0, adel}, 0);
    drive(0, 1, 32'h2FFC, 0, 0, 0);
    step();
    check("lo_adel", {31'b0, adel}, 1);

    drive(1, 1, 32'h3200, 0, 0, 0);
    step();
    drive(0, 1, 32'h3300, 0, 0, 0);
    step();
    check("live_beats_pend", pc, 32'h3300);
    check("live_pend_clr", {31'b0, pend}, 0);

    drive(1, 1, 32'h3400, 0, 0, 0);
    step();
    check("pend_before_rst", {31'b0, pend}, 1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("rst_in_pend_pc", pc, 32'h3000);
    check("rst_in_pend_pend", {31'b0, pend}, 0);
    reset = 1'b0;
    step();
    check("rst_in_pend_next", pc, 32'h3004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
